// File: rtl/inv_pipe_chain_if.sv
// inv_pipe_chain_if: handshake bundle for inv_pipe_chain.
//   in_valid/in_ready/in_data/in_mode : upstream beat channel (mode travels with the beat)
//   out_valid/out_ready/out_data      : downstream beat channel
//   master : drives the input channel and out_ready (producer/consumer side)
//   slave  : the pipeline itself
interface inv_pipe_chain_if #(
   parameter int unsigned WIDTH = 1
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/inv_pipe_chain.sv
// inv_pipe_chain: DEPTH registered stages with valid/ready handshake and bubble collapsing.
// Each stage k inverts the passing beat when the beat's mode is 1 and INV_MASK[k] is set.
// A saturating counter records how many accepted output beats differ from the previous one.
// Ports:
//   clock      : rising-edge clock
//   reset      : asynchronous, active-high
//   bus        : inv_pipe_chain_if.slave (in_valid/in_ready/in_data/in_mode,
//                out_valid/out_ready/out_data)
//   toggle_cnt : saturating count of output beats that differ from the previous output beat
//   busy       : any stage holds a beat
module inv_pipe_chain #(
   parameter int unsigned      WIDTH    = 1,
   parameter int unsigned      DEPTH    = 2,
   parameter logic [DEPTH-1:0] INV_MASK = {DEPTH{1'b1}},
   parameter int unsigned      CNT_W    = 8
) (
   input  logic             clock,
   input  logic             reset,
   inv_pipe_chain_if.slave  bus,
   output logic [CNT_W-1:0] toggle_cnt,
   output logic             busy
);

   localparam int D  = int'(DEPTH);
   // The last stage's mode is never consumed, so only DEPTH-1 mode bits are stored.
   localparam int MW = (D > 1) ? D - 1 : 1;

   logic [DEPTH-1:0] v_q;
   logic [WIDTH-1:0] d_q [DEPTH];
   logic [MW-1:0]    m_q;

   logic [DEPTH-1:0] adv;
   logic             adv_acc;
   logic [DEPTH-1:0] v_up;
   logic [DEPTH-1:0] m_up;
   logic [WIDTH-1:0] d_up [DEPTH];
   logic [WIDTH-1:0] d_ld [DEPTH];

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic             out_xfer;

   // A stage may load when it is empty or everything below it can move; scanning from the
   // output upwards lets an empty stage fill even while a stage further down is stalled.
   always_comb begin
      adv     = '0;
      adv_acc = bus.out_ready;
      for (int k = D - 1; k >= 0; k--) begin
         adv_acc = adv_acc | ~v_q[k];
         adv[k]  = adv_acc;
      end
   end

   always_comb begin
      v_up = '0;
      m_up = '0;
      for (int k = 0; k < D; k++) begin
         d_up[k] = '0;
      end
      v_up[0] = bus.in_valid;
      m_up[0] = bus.in_mode;
      d_up[0] = bus.in_data;
      for (int k = 1; k < D; k++) begin
         v_up[k] = v_q[k-1];
         m_up[k] = m_q[k-1];
         d_up[k] = d_q[k-1];
      end
      for (int k = 0; k < D; k++) begin
         d_ld[k] = (m_up[k] & INV_MASK[k]) ? ~d_up[k] : d_up[k];
      end
   end

   assign out_xfer = v_q[D-1] & bus.out_ready;

   always_comb begin
      cnt_d  = cnt_q;
      last_d = last_q;
      if (out_xfer) begin
         last_d = d_q[D-1];
         if ((d_q[D-1] != last_q) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         v_q    <= '0;
         m_q    <= '0;
         cnt_q  <= '0;
         last_q <= '0;
         for (int k = 0; k < D; k++) begin
            d_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < D; k++) begin
            if (adv[k]) begin
               v_q[k] <= v_up[k];
               d_q[k] <= d_ld[k];
            end
         end
         for (int k = 0; k < D - 1; k++) begin
            if (adv[k]) begin
               m_q[k] <= m_up[k];
            end
         end
         cnt_q  <= cnt_d;
         last_q <= last_d;
      end
   end

   assign bus.in_ready  = adv[0];
   assign bus.out_valid = v_q[D-1];
   assign bus.out_data  = d_q[D-1];
   assign toggle_cnt    = cnt_q;
   assign busy          = |v_q;

endmodule

// File: tb/tb_inv_pipe_chain.sv
// tb_inv_pipe_chain: scenario tasks for inv_pipe_chain on three configurations
//   u_a : WIDTH=8, DEPTH=4, INV_MASK=0111, CNT_W=8 (random traffic, stall, bubble, reset)
//   u_b : WIDTH=1, DEPTH=2, INV_MASK=11,   CNT_W=2 (basic latency, saturation)
//   u_c : WIDTH=1, DEPTH=3, INV_MASK=001,  CNT_W=8 (per-beat mode)
module tb_inv_pipe_chain;

   localparam int         DA     = 4;
   localparam logic [3:0] MASK_A = 4'b0111;
   localparam int         DB     = 2;
   localparam logic [1:0] MASK_B = 2'b11;
   localparam int         CB     = 2;
   localparam int         DC     = 3;
   localparam logic [2:0] MASK_C = 3'b001;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   inv_pipe_chain_if #(.WIDTH(8)) ifa ();
   inv_pipe_chain_if #(.WIDTH(1)) ifb ();
   inv_pipe_chain_if #(.WIDTH(1)) ifc ();

   logic [7:0]    tog_a;
   logic          busy_a;
   logic [CB-1:0] tog_b;
   logic          busy_b;
   logic [7:0]    tog_c;
   logic          busy_c;

   inv_pipe_chain #(.WIDTH(8), .DEPTH(DA), .INV_MASK(MASK_A), .CNT_W(8)) u_a (
      .clock(clock), .reset(reset), .bus(ifa), .toggle_cnt(tog_a), .busy(busy_a)
   );
   inv_pipe_chain #(.WIDTH(1), .DEPTH(DB), .INV_MASK(MASK_B), .CNT_W(CB)) u_b (
      .clock(clock), .reset(reset), .bus(ifb), .toggle_cnt(tog_b), .busy(busy_b)
   );
   inv_pipe_chain #(.WIDTH(1), .DEPTH(DC), .INV_MASK(MASK_C), .CNT_W(8)) u_c (
      .clock(clock), .reset(reset), .bus(ifc), .toggle_cnt(tog_c), .busy(busy_c)
   );

   always #5 clock = ~clock;

   // Net effect of a beat: inverted only if its mode is set and an odd number of stages invert.
   function automatic logic [7:0] ref_a(input logic [7:0] x, input logic m);
      return (m && ($countones(MASK_A) % 2 == 1)) ? ~x : x;
   endfunction
   function automatic logic ref_b(input logic x, input logic m);
      return (m && ($countones(MASK_B) % 2 == 1)) ? ~x : x;
   endfunction
   function automatic logic ref_c(input logic x, input logic m);
      return (m && ($countones(MASK_C) % 2 == 1)) ? ~x : x;
   endfunction

   task automatic idle_all;
      ifa.in_valid = 0; ifa.in_data = '0; ifa.in_mode = 0; ifa.out_ready = 0;
      ifb.in_valid = 0; ifb.in_data = '0; ifb.in_mode = 0; ifb.out_ready = 0;
      ifc.in_valid = 0; ifc.in_data = '0; ifc.in_mode = 0; ifc.out_ready = 0;
   endtask

   task automatic apply_reset;
      idle_all();
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      idle_all();
      reset = 1'b1;
      @(negedge clock);
      #1;
      n_tests++; if (ifa.out_valid !== 1'b0) begin n_fail++;
         $display("FAIL reset_out_valid: got %b want 0", ifa.out_valid); end
      n_tests++; if (ifa.in_ready !== 1'b1) begin n_fail++;
         $display("FAIL reset_in_ready: got %b want 1", ifa.in_ready); end
      n_tests++; if (busy_a !== 1'b0) begin n_fail++;
         $display("FAIL reset_busy: got %b want 0", busy_a); end
      n_tests++; if (tog_a !== 8'd0) begin n_fail++;
         $display("FAIL reset_toggle_cnt: got %0d want 0", tog_a); end
      n_tests++; if (ifa.out_data !== 8'd0) begin n_fail++;
         $display("FAIL reset_out_data: got %h want 00", ifa.out_data); end
      n_tests++; if ({busy_b, busy_c, ifb.out_valid, ifc.out_valid} !== 4'b0) begin n_fail++;
         $display("FAIL reset_other_cfgs: got %b want 0000",
                  {busy_b, busy_c, ifb.out_valid, ifc.out_valid}); end
      @(negedge clock);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++; if (ifa.out_valid !== 1'b0 || busy_a !== 1'b0) begin n_fail++;
            $display("FAIL reset_idle c%0d: got valid %b busy %b want 0 0",
                     c, ifa.out_valid, busy_a); end
         @(negedge clock);
      end
   endtask

   task automatic test_t1;
      logic exp_d;
      apply_reset();
      ifb.out_ready = 1'b1;
      ifb.in_mode   = 1'b1;
      for (int c = 0; c < 6; c++) begin
         ifb.in_valid = (c < 2);
         ifb.in_data  = (c == 1);
         #1;
         if (c < 2) begin
            n_tests++; if (ifb.in_ready !== 1'b1) begin n_fail++;
               $display("FAIL t1_in_ready c%0d: got %b want 1", c, ifb.in_ready); end
         end
         n_tests++; if (ifb.out_valid !== (c == 2 || c == 3)) begin n_fail++;
            $display("FAIL t1_out_valid c%0d: got %b want %b", c, ifb.out_valid,
                     (c == 2 || c == 3)); end
         if (c == 2 || c == 3) begin
            exp_d = ref_b(c == 3, 1'b1);
            n_tests++; if (ifb.out_data !== exp_d) begin n_fail++;
               $display("FAIL t1_out_data c%0d: got %b want %b", c, ifb.out_data, exp_d); end
         end
         @(negedge clock);
      end
      #1;
      n_tests++; if (tog_b !== 2'd1) begin n_fail++;
         $display("FAIL t1_toggle_cnt: got %0d want 1", tog_b); end
      @(negedge clock);
   endtask

   task automatic test_t2;
      logic modes [3];
      logic exp_d;
      modes = '{1'b1, 1'b0, 1'b1};
      apply_reset();
      ifc.out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (c < 3) begin
            ifc.in_valid = 1'b1; ifc.in_data = 1'b1; ifc.in_mode = modes[c];
         end else begin
            // mode flips while earlier beats are still inside the pipe
            ifc.in_valid = 1'b0; ifc.in_data = 1'($urandom); ifc.in_mode = ~ifc.in_mode;
         end
         #1;
         n_tests++; if (ifc.out_valid !== (c >= 3 && c <= 5)) begin n_fail++;
            $display("FAIL t2_out_valid c%0d: got %b want %b", c, ifc.out_valid,
                     (c >= 3 && c <= 5)); end
         if (c >= 3 && c <= 5) begin
            exp_d = ref_c(1'b1, modes[c-3]);
            n_tests++; if (ifc.out_data !== exp_d) begin n_fail++;
               $display("FAIL t2_out_data c%0d: got %b want %b", c, ifc.out_data, exp_d); end
         end
         @(negedge clock);
      end
      #1;
      n_tests++; if (tog_c !== 8'd2) begin n_fail++;
         $display("FAIL t2_toggle_cnt: got %0d want 2", tog_c); end
      @(negedge clock);
   endtask

   task automatic test_t3_full_stall;
      logic [7:0] q[$];
      int sent, got;
      apply_reset();
      sent = 0; got = 0;
      for (int c = 0; c < 40 && got < 6; c++) begin
         ifa.out_ready = (c >= 7);
         ifa.in_valid  = (sent < 6);
         ifa.in_data   = 8'($urandom);
         ifa.in_mode   = 1'($urandom);
         #1;
         if (c < 4) begin
            n_tests++; if (ifa.in_ready !== 1'b1) begin n_fail++;
               $display("FAIL t3_fill_ready c%0d: got %b want 1", c, ifa.in_ready); end
         end else if (c < 7) begin
            n_tests++; if (ifa.in_ready !== 1'b0 || busy_a !== 1'b1) begin n_fail++;
               $display("FAIL t3_full c%0d: got ready %b busy %b want 0 1",
                        c, ifa.in_ready, busy_a); end
            n_tests++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== q[0]) begin n_fail++;
               $display("FAIL t3_hold c%0d: got %b/%h want 1/%h",
                        c, ifa.out_valid, ifa.out_data, q[0]); end
         end else begin
            if (c == 7) begin
               n_tests++; if (ifa.in_ready !== 1'b1) begin n_fail++;
                  $display("FAIL t3_ready_follows_out_ready: got %b want 1", ifa.in_ready); end
            end
            n_tests++; if (ifa.out_valid !== 1'b1) begin n_fail++;
               $display("FAIL t3_gap c%0d: got out_valid %b want 1", c, ifa.out_valid); end
         end
         if (ifa.out_valid && ifa.out_ready && q.size() != 0) begin
            n_tests++; if (ifa.out_data !== q[0]) begin n_fail++;
               $display("FAIL t3_order beat%0d: got %h want %h", got, ifa.out_data, q[0]); end
            void'(q.pop_front());
            got++;
         end
         if (ifa.in_valid && ifa.in_ready) begin
            q.push_back(ref_a(ifa.in_data, ifa.in_mode));
            sent++;
         end
         @(negedge clock);
      end
      n_tests++; if (got != 6 || sent != 6) begin n_fail++;
         $display("FAIL t3_count: got %0d out %0d in want 6 6", got, sent); end
   endtask

   task automatic test_t4_bubble;
      logic [7:0] q[$];
      int lat;
      bit seen;
      apply_reset();
      lat = -1; seen = 0;
      for (int c = 0; c < 12 && !seen; c++) begin
         ifa.in_valid = (c == 0);
         ifa.in_data  = 8'($urandom);
         ifa.in_mode  = 1'($urandom);
         #1;
         if (ifa.in_valid && ifa.in_ready) q.push_back(ref_a(ifa.in_data, ifa.in_mode));
         if (ifa.out_valid) begin seen = 1; lat = c; end
         @(negedge clock);
      end
      n_tests++; if (lat != DA) begin n_fail++;
         $display("FAIL t4_latency: got %0d want %0d", lat, DA); end
      // Y, three idle cycles, then Z, W, V; only V must be refused.
      for (int c = 0; c < 7; c++) begin
         ifa.in_valid = (c == 0 || c >= 4);
         ifa.in_data  = 8'($urandom);
         ifa.in_mode  = 1'($urandom);
         #1;
         n_tests++; if (ifa.in_ready !== (c != 6)) begin n_fail++;
            $display("FAIL t4_in_ready c%0d: got %b want %b", c, ifa.in_ready, (c != 6)); end
         n_tests++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== q[0]) begin n_fail++;
            $display("FAIL t4_stalled_out c%0d: got %b/%h want 1/%h",
                     c, ifa.out_valid, ifa.out_data, q[0]); end
         if (ifa.in_valid && ifa.in_ready) q.push_back(ref_a(ifa.in_data, ifa.in_mode));
         @(negedge clock);
      end
      ifa.in_valid  = 1'b0;
      ifa.out_ready = 1'b1;
      for (int c = 0; c < 12 && q.size() != 0; c++) begin
         #1;
         if (ifa.out_valid) begin
            n_tests++; if (ifa.out_data !== q[0]) begin n_fail++;
               $display("FAIL t4_order: got %h want %h", ifa.out_data, q[0]); end
            void'(q.pop_front());
         end
         @(negedge clock);
      end
      n_tests++; if (q.size() != 0) begin n_fail++;
         $display("FAIL t4_drain: got %0d beats left want 0", q.size()); end
   endtask

   task automatic test_t5_saturate;
      logic q[$];
      logic last_m;
      int   tog_m, sent;
      apply_reset();
      last_m = 1'b0; tog_m = 0; sent = 0;
      ifb.out_ready = 1'b1;
      for (int c = 0; c < 14; c++) begin
         ifb.in_valid = (sent < 6);
         ifb.in_data  = sent[0];
         ifb.in_mode  = 1'($urandom);
         #1;
         n_tests++; if (tog_b !== CB'(tog_m)) begin n_fail++;
            $display("FAIL t5_toggle_cnt c%0d: got %0d want %0d", c, tog_b, tog_m); end
         if (ifb.out_valid && ifb.out_ready && q.size() != 0) begin
            n_tests++; if (ifb.out_data !== q[0]) begin n_fail++;
               $display("FAIL t5_out_data c%0d: got %b want %b", c, ifb.out_data, q[0]); end
            if (q[0] != last_m && tog_m < (1 << CB) - 1) tog_m++;
            last_m = q.pop_front();
         end
         if (ifb.in_valid && ifb.in_ready) begin
            q.push_back(ref_b(ifb.in_data, ifb.in_mode));
            sent++;
         end
         @(negedge clock);
      end
      #1;
      n_tests++; if (tog_b !== 2'd3 || q.size() != 0) begin n_fail++;
         $display("FAIL t5_final: got cnt %0d left %0d want 3 0", tog_b, q.size()); end
      @(negedge clock);
   endtask

   task automatic test_t6_reset_inflight;
      logic [7:0] pat [4];
      logic [7:0] q[$];
      logic [7:0] exp_d;
      int lat;
      bit seen;
      pat = '{8'hA5, 8'h5A, 8'h00, 8'hFF};
      apply_reset();
      ifa.out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         ifa.in_valid = (c < 4);
         ifa.in_data  = (c < 4) ? pat[c] : 8'h00;
         ifa.in_mode  = 1'b0;
         #1;
         if (ifa.in_valid && ifa.in_ready) q.push_back(ref_a(ifa.in_data, ifa.in_mode));
         if (ifa.out_valid && q.size() != 0) void'(q.pop_front());
         @(negedge clock);
      end
      #1;
      // outputs 0 -> A5 -> 5A -> 00 -> FF each differ from their predecessor
      n_tests++; if (tog_a !== 8'd4) begin n_fail++;
         $display("FAIL t6_pre_toggle: got %0d want 4", tog_a); end
      @(negedge clock);
      ifa.out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         ifa.in_valid = (c < 3);
         ifa.in_data  = 8'($urandom);
         @(negedge clock);
      end
      #1;
      n_tests++; if (busy_a !== 1'b1 || ifa.out_valid !== 1'b1) begin n_fail++;
         $display("FAIL t6_pre_busy: got busy %b valid %b want 1 1", busy_a, ifa.out_valid); end
      #1;
      reset = 1'b1;
      #1;
      n_tests++; if (ifa.out_valid !== 1'b0 || busy_a !== 1'b0) begin n_fail++;
         $display("FAIL t6_async_clear: got valid %b busy %b want 0 0", ifa.out_valid, busy_a); end
      n_tests++; if (tog_a !== 8'd0 || ifa.in_ready !== 1'b1) begin n_fail++;
         $display("FAIL t6_async_cnt: got cnt %0d ready %b want 0 1", tog_a, ifa.in_ready); end
      @(negedge clock);
      reset = 1'b0;
      ifa.out_ready = 1'b1;
      lat = -1; seen = 0; exp_d = 8'h00;
      for (int c = 0; c < 12 && !seen; c++) begin
         ifa.in_valid = (c == 3);
         ifa.in_data  = 8'($urandom);
         ifa.in_mode  = 1'($urandom);
         #1;
         if (c == 3) exp_d = ref_a(ifa.in_data, ifa.in_mode);
         if (ifa.out_valid) begin
            seen = 1; lat = c - 3;
            n_tests++; if (ifa.out_data !== exp_d) begin n_fail++;
               $display("FAIL t6_post_data: got %h want %h", ifa.out_data, exp_d); end
         end
         @(negedge clock);
      end
      n_tests++; if (lat != DA) begin n_fail++;
         $display("FAIL t6_post_latency: got %0d want %0d", lat, DA); end
   endtask

   task automatic test_random;
      logic [7:0] q[$];
      logic [7:0] last_m;
      int  tog_m, wait_c;
      bit  stall_prev, exp_rdy;
      apply_reset();
      last_m = 8'h00; tog_m = 0; wait_c = 0; stall_prev = 0;
      for (int c = 0; c < 460; c++) begin
         ifa.in_valid  = (c < 400) && ($urandom_range(0, 9) < 7);
         ifa.in_data   = 8'($urandom);
         ifa.in_mode   = 1'($urandom);
         ifa.out_ready = (c >= 400) || ($urandom_range(0, 9) < 6);
         #1;
         exp_rdy = !((q.size() == DA) && !ifa.out_ready);
         n_tests++; if (ifa.in_ready !== exp_rdy) begin n_fail++;
            $display("FAIL rnd_in_ready c%0d: got %b want %b", c, ifa.in_ready, exp_rdy); end
         n_tests++; if (busy_a !== (q.size() != 0)) begin n_fail++;
            $display("FAIL rnd_busy c%0d: got %b want %b", c, busy_a, (q.size() != 0)); end
         n_tests++; if (tog_a !== 8'(tog_m)) begin n_fail++;
            $display("FAIL rnd_toggle_cnt c%0d: got %0d want %0d", c, tog_a, tog_m); end
         if (stall_prev) begin
            n_tests++; if (ifa.out_valid !== 1'b1) begin n_fail++;
               $display("FAIL rnd_stall_hold c%0d: got out_valid %b want 1", c, ifa.out_valid); end
         end
         if (ifa.out_valid) begin
            wait_c = 0;
            n_tests++; if (q.size() == 0 || ifa.out_data !== q[0]) begin n_fail++;
               $display("FAIL rnd_out_data c%0d: got %h want %h (queued %0d)",
                        c, ifa.out_data, (q.size() != 0) ? q[0] : 8'h00, q.size()); end
         end else if (q.size() != 0) begin
            wait_c++;
            n_tests++; if (wait_c >= DA) begin n_fail++;
               $display("FAIL rnd_latency c%0d: got %0d empty cycles want < %0d", c, wait_c, DA); end
         end
         if (ifa.out_valid && ifa.out_ready && q.size() != 0) begin
            if (q[0] != last_m && tog_m < 255) tog_m++;
            last_m = q.pop_front();
         end
         if (ifa.in_valid && ifa.in_ready) q.push_back(ref_a(ifa.in_data, ifa.in_mode));
         stall_prev = ifa.out_valid && !ifa.out_ready;
         @(negedge clock);
      end
      n_tests++; if (q.size() != 0) begin n_fail++;
         $display("FAIL rnd_drain: got %0d beats left want 0", q.size()); end
   endtask

   initial begin
      idle_all();
      test_reset();
      test_t1();
      test_t2();
      test_t3_full_stall();
      test_t4_bubble();
      test_t5_saturate();
      test_t6_reset_inflight();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
